// File: rtl/arbitro_contador.sv
// Round-robin arbiter and sequencer for a shared saturating occupancy counter.
// Each arbitration slot grants at most one +1 or -1 request, then spends one
// cycle in ACK while the one-hot grant pulse is visible to the requesters.
module arbitro_contador #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_inc,
  input  logic [NREQ-1:0]  req_dec,
  output logic [NREQ-1:0]  gnt_inc,
  output logic [NREQ-1:0]  gnt_dec,
  output logic [WIDTH-1:0] cuenta,
  output logic             empty,
  output logic             full,
  output logic             ocupado
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, ACK} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr_inc, ptr_dec, ptr_inc_nxt, ptr_dec_nxt;
  logic             pref, pref_nxt;
  logic [WIDTH-1:0] cuenta_nxt;
  logic [NREQ-1:0]  gnt_inc_nxt, gnt_dec_nxt;
  logic             inc_ok, dec_ok, pick_inc;
  logic [PW-1:0]    win_inc, win_dec;

  assign empty   = (cuenta == '0);
  assign full    = &cuenta;
  assign ocupado = (state == ACK);

  // First set request at or above ptr, wrapping at NREQ (not at 2**PW).
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [PW-1:0]   ptr);
    int unsigned   idx;
    logic [PW-1:0] idx_pw;
    logic          found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = k + int'(unsigned'(ptr));
      if (idx >= NREQ) idx = idx - NREQ;
      idx_pw = PW'(idx);
      if (!found && req[idx_pw]) begin
        rr_pick = idx_pw;
        found   = 1'b1;
      end
    end
  endfunction

  // Pointer successor, modulo NREQ.
  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] w);
    int unsigned n;
    n = int'(unsigned'(w)) + 1;
    if (n >= NREQ) n = 0;
    return PW'(n);
  endfunction

  // Next-state, arbitration and counter update.
  always_comb begin
    state_nxt   = state;
    cuenta_nxt  = cuenta;
    ptr_inc_nxt = ptr_inc;
    ptr_dec_nxt = ptr_dec;
    pref_nxt    = pref;
    gnt_inc_nxt = '0;
    gnt_dec_nxt = '0;
    inc_ok      = (|req_inc) && !full;
    dec_ok      = (|req_dec) && !empty;
    pick_inc    = inc_ok && (!dec_ok || !pref);
    win_inc     = rr_pick(req_inc, ptr_inc);
    win_dec     = rr_pick(req_dec, ptr_dec);
    case (state)
      ARB: begin
        if (inc_ok || dec_ok) begin
          state_nxt = ACK;
          if (inc_ok && dec_ok) pref_nxt = !pref;
          if (pick_inc) begin
            gnt_inc_nxt = NREQ'(1) << win_inc;
            cuenta_nxt  = cuenta + WIDTH'(1);
            ptr_inc_nxt = rr_next(win_inc);
          end else begin
            gnt_dec_nxt = NREQ'(1) << win_dec;
            cuenta_nxt  = cuenta - WIDTH'(1);
            ptr_dec_nxt = rr_next(win_dec);
          end
        end
      end
      ACK: state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // State, counter, pointers and registered grant pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      cuenta  <= '0;
      ptr_inc <= '0;
      ptr_dec <= '0;
      pref    <= 1'b0;
      gnt_inc <= '0;
      gnt_dec <= '0;
    end else begin
      state   <= state_nxt;
      cuenta  <= cuenta_nxt;
      ptr_inc <= ptr_inc_nxt;
      ptr_dec <= ptr_dec_nxt;
      pref    <= pref_nxt;
      gnt_inc <= gnt_inc_nxt;
      gnt_dec <= gnt_dec_nxt;
    end
  end

endmodule

// File: tb/tb_arbitro_contador.sv
// Bench for arbitro_contador: scenario tasks push expected grant events to a
// queue, a requester agent records observed grants, and each task compares.
module tb_arbitro_contador;

  localparam int W = 4;
  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] inc;
    logic [N-1:0] dec;
    logic [W-1:0] cnt;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_inc, req_dec, gnt_inc, gnt_dec;
  logic [W-1:0] cuenta;
  logic         empty, full, ocupado;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  fails  = 0;

  arbitro_contador #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_inc(req_inc), .req_dec(req_dec),
    .gnt_inc(gnt_inc), .gnt_dec(gnt_dec), .cuenta(cuenta),
    .empty(empty), .full(full), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk(input logic [N-1:0] i, input logic [N-1:0] d,
                             input logic [W-1:0] c);
    ev_t e;
    e.inc = i; e.dec = d; e.cnt = c;
    return e;
  endfunction

  // Requester agent: optionally drops a granted request in the grant cycle
  // and re-raises it in the following ARB cycle; records every grant seen.
  task automatic run_agent(input int n, input bit drop, input bit reraise);
    logic [N-1:0] back_inc, back_dec;
    back_inc = '0;
    back_dec = '0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (reraise) begin
        req_inc = req_inc | back_inc;
        req_dec = req_dec | back_dec;
      end
      back_inc = '0;
      back_dec = '0;
      if ((gnt_inc != '0) || (gnt_dec != '0)) begin
        obs_q.push_back(mk(gnt_inc, gnt_dec, cuenta));
        if (drop) begin
          back_inc = gnt_inc;
          back_dec = gnt_dec;
          req_inc  = req_inc & ~gnt_inc;
          req_dec  = req_dec & ~gnt_dec;
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    req_inc = '0;
    req_dec = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Reach a given count by repeated increments from requester 0.
  task automatic preload(input int n);
    apply_reset();
    req_inc = 4'b0001;
    run_agent(2 * n, 1'b1, 1'b1);
    req_inc = '0;
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_inc = '0; req_dec = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cuenta, gnt_inc, gnt_dec, empty, full, ocupado} !== {4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got cnt=%0d gi=%b gd=%b e=%b f=%b o=%b, want 0 0000 0000 1 0 0",
               cuenta, gnt_inc, gnt_dec, empty, full, ocupado);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin_inc();
    ev_t e, o;
    apply_reset();
    exp_q.push_back(mk(4'b0001, 4'b0000, 4'd1));
    exp_q.push_back(mk(4'b0010, 4'b0000, 4'd2));
    exp_q.push_back(mk(4'b0100, 4'b0000, 4'd3));
    exp_q.push_back(mk(4'b1000, 4'b0000, 4'd4));
    exp_q.push_back(mk(4'b0001, 4'b0000, 4'd5));
    req_inc = 4'b1111;
    run_agent(9, 1'b1, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL rr_inc_count: got %0d grants, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL rr_inc_grant: got gi=%b gd=%b cnt=%0d, want gi=%b gd=%b cnt=%0d",
                 o.inc, o.dec, o.cnt, e.inc, e.dec, e.cnt);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Runs straight after the round-robin test, which ends in ACK with count 5.
  task automatic test_reset_mid_ack();
    checks++;
    if ({ocupado, cuenta} !== {1'b1, 4'd5}) begin
      fails++;
      $display("FAIL pre_reset_ack: got o=%b cnt=%0d, want o=1 cnt=5", ocupado, cuenta);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cuenta, gnt_inc, gnt_dec, empty, ocupado} !== {4'd0, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid_ack: got cnt=%0d gi=%b gd=%b e=%b o=%b, want 0 0000 0000 1 0",
               cuenta, gnt_inc, gnt_dec, empty, ocupado);
    end
    req_inc = '0; req_dec = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_full_saturation();
    ev_t e, o;
    preload(15);
    checks++;
    if ({cuenta, full, empty} !== {4'd15, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL full_preload: got cnt=%0d f=%b e=%b, want 15 1 0", cuenta, full, empty);
    end
    req_inc = 4'b0010;
    run_agent(10, 1'b1, 1'b1);
    checks++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL full_no_grant: got %0d grants, want 0", obs_q.size());
    end
    checks++;
    if ({cuenta, full} !== {4'd15, 1'b1}) begin
      fails++;
      $display("FAIL full_hold: got cnt=%0d f=%b, want 15 1", cuenta, full);
    end
    obs_q.delete();
    exp_q.push_back(mk(4'b0000, 4'b0001, 4'd14));
    exp_q.push_back(mk(4'b0010, 4'b0000, 4'd15));
    req_dec = 4'b0001;
    run_agent(6, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL full_release_count: got %0d grants, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL full_release_grant: got gi=%b gd=%b cnt=%0d, want gi=%b gd=%b cnt=%0d",
                 o.inc, o.dec, o.cnt, e.inc, e.dec, e.cnt);
      end
    end
    exp_q.delete(); obs_q.delete();
    req_inc = '0; req_dec = '0;
  endtask

  task automatic test_empty_saturation();
    ev_t e, o;
    apply_reset();
    req_dec = 4'b1000;
    run_agent(5, 1'b1, 1'b1);
    checks++;
    if (obs_q.size() != 0 || cuenta !== 4'd0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL empty_hold: got grants=%0d cnt=%0d e=%b, want 0 0 1", obs_q.size(), cuenta, empty);
    end
    obs_q.delete();
    exp_q.push_back(mk(4'b1000, 4'b0000, 4'd1));
    exp_q.push_back(mk(4'b0000, 4'b1000, 4'd0));
    req_inc = 4'b1000;
    run_agent(6, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL empty_release_count: got %0d grants, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL empty_release_grant: got gi=%b gd=%b cnt=%0d, want gi=%b gd=%b cnt=%0d",
                 o.inc, o.dec, o.cnt, e.inc, e.dec, e.cnt);
      end
    end
    exp_q.delete(); obs_q.delete();
    req_inc = '0; req_dec = '0;
  endtask

  task automatic test_contention();
    ev_t e, o;
    preload(8);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(4'b0001, 4'b0000, 4'd9));
      exp_q.push_back(mk(4'b0000, 4'b0100, 4'd8));
    end
    req_inc = 4'b0001;
    req_dec = 4'b0100;
    run_agent(8, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL contention_count: got %0d grants, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL contention_grant: got gi=%b gd=%b cnt=%0d, want gi=%b gd=%b cnt=%0d",
                 o.inc, o.dec, o.cnt, e.inc, e.dec, e.cnt);
      end
    end
    exp_q.delete(); obs_q.delete();
    req_inc = '0; req_dec = '0;
  endtask

  task automatic test_pointer_wrap();
    ev_t e, o;
    preload(3);
    exp_q.push_back(mk(4'b0000, 4'b0001, 4'd2));
    exp_q.push_back(mk(4'b0000, 4'b1000, 4'd1));
    exp_q.push_back(mk(4'b0000, 4'b0001, 4'd0));
    req_dec = 4'b1001;
    run_agent(8, 1'b1, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL wrap_count: got %0d grants, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL wrap_grant: got gi=%b gd=%b cnt=%0d, want gi=%b gd=%b cnt=%0d",
                 o.inc, o.dec, o.cnt, e.inc, e.dec, e.cnt);
      end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if ({cuenta, empty} !== {4'd0, 1'b1}) begin
      fails++;
      $display("FAIL wrap_final: got cnt=%0d e=%b, want 0 1", cuenta, empty);
    end
    req_inc = '0; req_dec = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin_inc();
    test_reset_mid_ack();
    test_full_saturation();
    test_empty_saturation();
    test_contention();
    test_pointer_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
